// File: rtl/alu32i_if.sv
// Execute-stage ALU bus: operands and decoded select in, registered result and flags out.
interface alu32i_if;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  selectop;
   logic [31:0] out;
   logic        neq;
   logic        eq;
   logic        lt;
   logic        ge;
   logic        zerof;
   logic        negativef;
   logic        carryf;

   modport master (
      output a, b, selectop,
      input  out, neq, eq, lt, ge, zerof, negativef, carryf
   );

   modport slave (
      input  a, b, selectop,
      output out, neq, eq, lt, ge, zerof, negativef, carryf
   );
endinterface

// File: rtl/alu32i.sv
// RV32I integer ALU: one-cycle registered result plus comparison/status flags for
// the branch unit. Select is {funct7[5], funct3}.
module alu32i (
   input  logic      clk,
   input  logic      rst,
   alu32i_if.slave   bus
);
   logic        is_sub;
   logic [31:0] b_add;
   logic [32:0] sum;
   logic [31:0] res;
   logic        carry;
   logic [4:0]  shamt;
   logic        lt_s;

   // Subtract shares the adder: a + ~b + 1, so bit 32 is the "no borrow" flag.
   assign is_sub = (bus.selectop == 4'b1000);
   assign b_add  = is_sub ? ~bus.b : bus.b;
   assign sum    = {1'b0, bus.a} + {1'b0, b_add} + {32'b0, is_sub};
   assign shamt  = bus.b[4:0];
   assign lt_s   = $signed(bus.a) < $signed(bus.b);

   always_comb begin
      res   = '0;
      carry = 1'b0;
      case (bus.selectop[2:0])
         3'b000: begin
            res   = sum[31:0];
            carry = sum[32];
         end
         3'b001: res = bus.a << shamt;
         3'b010: res = {31'b0, lt_s};
         3'b011: res = {31'b0, bus.a < bus.b};
         3'b100: res = bus.a ^ bus.b;
         3'b101: res = bus.selectop[3] ? 32'($signed(bus.a) >>> shamt) : (bus.a >> shamt);
         3'b110: res = bus.a | bus.b;
         3'b111: res = bus.a & bus.b;
         default: res = '0;
      endcase
   end

   // zerof/negativef come from the value being registered so they track out exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out       <= '0;
         bus.neq       <= 1'b0;
         bus.eq        <= 1'b0;
         bus.lt        <= 1'b0;
         bus.ge        <= 1'b0;
         bus.zerof     <= 1'b0;
         bus.negativef <= 1'b0;
         bus.carryf    <= 1'b0;
      end else begin
         bus.out       <= res;
         bus.neq       <= (bus.a != bus.b);
         bus.eq        <= (bus.a == bus.b);
         bus.lt        <= lt_s;
         bus.ge        <= ~lt_s;
         bus.zerof     <= (res == 32'd0);
         bus.negativef <= res[31];
         bus.carryf    <= carry;
      end
   end
endmodule

// File: tb/tb_alu32i.sv
// Randomized bench for alu32i: behavioural reference model checked every cycle,
// plus literal expectations from hand-worked cases.
module tb_alu32i;
   typedef struct packed {
      logic [31:0] o;
      logic [6:0]  f;   // {neq, eq, lt, ge, zerof, negativef, carryf}
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   res_t exp_r = '0;
   logic exp_vld = 1'b0;

   alu32i_if bus ();
   alu32i dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] s);
      res_t        r;
      logic [63:0] wide;
      logic [31:0] o;
      logic        c;
      int          sh;
      logic        slt;
      sh  = int'(y % 32);
      slt = (int'(x) < int'(y));
      c   = 1'b0;
      o   = '0;
      case (s[2:0])
         3'd0: if (s[3]) begin
                  o = x - y;
                  c = (x >= y);
               end else begin
                  wide = {32'b0, x} + {32'b0, y};
                  o = wide[31:0];
                  c = wide[32];
               end
         3'd1: o = x << sh;
         3'd2: o = slt ? 32'd1 : 32'd0;
         3'd3: o = (x < y) ? 32'd1 : 32'd0;
         3'd4: o = x ^ y;
         3'd5: o = s[3] ? 32'(int'(x) >>> sh) : (x >> sh);
         3'd6: o = x | y;
         default: o = x & y;
      endcase
      r.o = o;
      r.f = {x != y, x == y, slt, !slt, o == 32'd0, o[31], c};
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Model samples the same edge as the DUT.
   always @(posedge clk) begin
      exp_r   <= rst ? '0 : model(bus.a, bus.b, bus.selectop);
      exp_vld <= 1'b1;
   end

   always @(negedge clk) begin
      if (exp_vld) begin
         chk("model_out", bus.out, exp_r.o);
         chk("model_flags", {25'b0, bus.neq, bus.eq, bus.lt, bus.ge, bus.zerof, bus.negativef, bus.carryf},
             {25'b0, exp_r.f});
      end
   end

   task automatic op(input logic [31:0] x, input logic [31:0] y, input logic [3:0] s);
      @(negedge clk);
      bus.a = x;
      bus.b = y;
      bus.selectop = s;
      @(posedge clk);
      #1;
   endtask

   logic [3:0]  t_sel [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                               4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
   logic [31:0] t_out [10] = '{32'hFFFFFFC8, 32'hFFFFFFBE, 32'hFFFFF860, 32'h1, 32'h0,
                               32'hFFFFFFC6, 32'h07FFFFFE, 32'hFFFFFFFE, 32'hFFFFFFC7, 32'h1};
   logic        t_cy  [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      res_t m;
      bus.a = 32'd5;
      bus.b = 32'd5;
      bus.selectop = 4'b0000;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out", bus.out, 32'd0);
      chk("reset_flags", {25'b0, bus.neq, bus.eq, bus.lt, bus.ge, bus.zerof, bus.negativef, bus.carryf}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("first_out", bus.out, 32'h0000000A);
      chk("first_eq_ge", {30'b0, bus.eq, bus.ge}, 32'd3);

      // Pin the model itself against hand-worked values.
      m = model(32'hFFFFFFC3, 32'd5, 4'b1101);
      chk("model_sra_pin", m.o, 32'hFFFFFFFE);
      m = model(32'd3, 32'd7, 4'b1000);
      chk("model_sub_pin", {m.o[31:1], m.f[0]}, {31'h7FFFFFFE, 1'b0});

      for (int i = 0; i < 10; i++) begin
         op(32'hFFFFFFC3, 32'd5, t_sel[i]);
         chk($sformatf("neg61_out_%b", t_sel[i]), bus.out, t_out[i]);
         chk($sformatf("neg61_cmp_%b", t_sel[i]), {28'b0, bus.neq, bus.eq, bus.lt, bus.ge}, 32'b1010);
         chk($sformatf("neg61_cy_%b", t_sel[i]), {31'b0, bus.carryf}, {31'b0, t_cy[i]});
         chk($sformatf("neg61_neg_%b", t_sel[i]), {31'b0, bus.negativef}, {31'b0, t_out[i][31]});
      end

      op(32'h80000000, 32'h21, 4'b0001);  chk("mask_sll", bus.out, 32'h0);
      op(32'h80000000, 32'h21, 4'b0101);  chk("mask_srl", bus.out, 32'h40000000);
      op(32'h80000000, 32'h21, 4'b1101);  chk("mask_sra", bus.out, 32'hC0000000);

      op(32'hFFFFFFFF, 32'd1, 4'b0000);
      chk("add_wrap", {bus.out[30:0], bus.zerof, bus.carryf}, {31'b0, 2'b11});
      op(32'd3, 32'd7, 4'b1000);
      chk("sub_borrow", bus.out, 32'hFFFFFFFC);
      chk("sub_flags", {29'b0, bus.carryf, bus.negativef, bus.lt}, 32'b011);
      op(32'd1, 32'hFFFFFFFF, 4'b0011);
      chk("sltu_vs_lt", {bus.out[30:0], bus.lt}, {31'd1, 1'b0});

      // Aliases: upper-bit codes of non-add/shift funct3 must match the plain ones.
      for (int i = 0; i < 6; i++) begin
         logic [31:0] x, y, r0;
         logic [3:0]  codes [6] = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110, 4'b1111};
         x = $urandom;
         y = $urandom;
         op(x, y, codes[i] & 4'b0111);
         r0 = bus.out;
         op(x, y, codes[i]);
         chk($sformatf("alias_%b", codes[i]), bus.out, r0);
      end

      // Back-to-back, then a longer random run with occasional mid-stream reset.
      for (int i = 0; i < 16; i++) op($urandom, $urandom, 4'($urandom_range(0, 15)));
      for (int i = 0; i < 400; i++) begin
         logic [31:0] x, y;
         x = $urandom;
         case ($urandom_range(0, 3))
            0: y = x;
            1: y = $urandom_range(0, 40);
            default: y = $urandom;
         endcase
         @(negedge clk);
         rst = ($urandom_range(0, 29) == 0);
         bus.a = x;
         bus.b = y;
         bus.selectop = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
